// File: rtl/ft_regfile_recovery.sv
// ---------------------------------------------------------------------------
// ft_regfile_recovery
//
// Recovery datapath that sits behind the fault-tolerance controller. When the
// controller raises its recover request, this block streams the architectural
// register file out of the healthy core and writes it into both cores. It
// then restores the last checkpointed PC and answers with a one-cycle done
// pulse that the controller consumes as recovery_done.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_i            asynchronous active-high reset
//   start_i          recover request (level); its rising edge in IDLE starts
//   load_pc_i        checkpoint enable; pc_i is captured while high in IDLE
//   source_sel_i     healthy core select (0 = core A, 1 = core B)
//   pc_i             committed PC from the pipeline
//   rf_re_o          register-file read enable towards the source core
//   rf_raddr_o       read address (0 while rf_re_o is low)
//   rf_rdata_a_i     core A read data, valid one cycle after the address
//   rf_rdata_b_i     core B read data, same timing as core A
//   rf_we_o          write enable, broadcast to both cores
//   rf_waddr_o       write address (0 while rf_we_o is low)
//   rf_wdata_o       write data, taken from the selected core's read port
//   pc_we_o          PC restore strobe
//   pc_o             checkpointed PC
//   busy_o           recovery in progress
//   recovery_done_o  one-cycle completion pulse
//   recovery_count_o completed recoveries, saturating at 255
// ---------------------------------------------------------------------------
module ft_regfile_recovery #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  load_pc_i,
  input  logic                  source_sel_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  rf_re_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  pc_we_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  busy_o,
  output logic                  recovery_done_o,
  output logic [7:0]            recovery_count_o
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COPY       = 3'd1;
  localparam logic [2:0] ST_DRAIN      = 3'd2;
  localparam logic [2:0] ST_PC_RESTORE = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_startQ;
  logic                  r_srcSel;
  logic                  r_wrValid;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [7:0]            r_count;

  logic w_idle;
  logic w_copy;
  logic w_startEdge;
  logic w_lastReg;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_copy    = (r_state == ST_COPY);
  assign w_lastReg = (r_cnt == LAST_ADDR);

  // Only a fresh rising edge seen while idle starts a recovery. Edges during
  // a recovery are dropped, and a level still high after DONE has start_q
  // already set, so it cannot retrigger.
  assign w_startEdge = w_idle & start_i & ~r_startQ;

  // Delayed copy of the request, used for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_startQ <= 1'b0;
    end else begin
      r_startQ <= start_i;
    end
  end

  // PC checkpoint. Only sampled while idle so pipeline activity during a
  // recovery cannot disturb the value that is about to be restored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= '0;
    end else if (w_idle && load_pc_i) begin
      r_pc <= pc_i;
    end
  end

  // Sequencer. The source core is latched at start so the selection stays
  // stable for the whole copy even if the controller changes its mind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_srcSel <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startEdge) begin
            r_cnt    <= '0;
            r_srcSel <= source_sel_i;
            r_state  <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (w_lastReg) begin
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          r_state <= ST_PC_RESTORE;
        end
        ST_PC_RESTORE: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write stage: each read issued in COPY becomes a write one cycle later,
  // lining up with the synchronous read data of the source core.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrValid <= 1'b0;
      r_wrAddr  <= '0;
    end else if (w_copy) begin
      r_wrValid <= 1'b1;
      r_wrAddr  <= r_cnt;
    end else begin
      r_wrValid <= 1'b0;
      r_wrAddr  <= '0;
    end
  end

  // Completed-recovery counter, holding at its maximum instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if ((r_state == ST_DONE) && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // All strobes decode straight from registers, so reset clears them
  // without waiting for a clock edge.
  assign rf_re_o          = w_copy;
  assign rf_raddr_o       = w_copy ? r_cnt : '0;
  assign rf_we_o          = r_wrValid;
  assign rf_waddr_o       = r_wrValid ? r_wrAddr : '0;
  assign rf_wdata_o       = r_srcSel ? rf_rdata_b_i : rf_rdata_a_i;
  assign pc_we_o          = (r_state == ST_PC_RESTORE);
  assign pc_o             = r_pc;
  assign busy_o           = ~w_idle;
  assign recovery_done_o  = (r_state == ST_DONE);
  assign recovery_count_o = r_count;

endmodule

// File: doc/ft_regfile_recovery.md
Name: ft_regfile_recovery

Overview:
- Datapath stage directly downstream of the fault-tolerance controller.
- When the controller asserts its recover output, this block copies the architectural register file from the healthy core into both cores. It then restores the last checkpointed PC and returns a single-cycle done pulse, which the controller consumes as recovery_done.
- It sits between the controller and the register-file / PC write ports of the duplicated cores.

Parameters:
- NUM_REGS, 32, number of register-file entries copied (addresses 0..NUM_REGS-1).
- ADDR_WIDTH, 5, register address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- DATA_WIDTH, 32, register and PC width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  recover request from the controller (level); rising edge starts a recovery.
- load_pc_i  in  1  checkpoint enable from the controller; PC captured while high.
- source_sel_i  in  1  healthy core (0 = core A, 1 = core B); sampled at start.
- pc_i  in  DATA_WIDTH  committed PC from the pipeline.
- rf_re_o  out  1  register-file read enable to the source core.
- rf_raddr_o  out  ADDR_WIDTH  read address.
- rf_rdata_a_i  in  DATA_WIDTH  core A read data; synchronous read, valid one cycle after address.
- rf_rdata_b_i  in  DATA_WIDTH  core B read data; same timing as core A.
- rf_we_o  out  1  write enable, broadcast to both cores.
- rf_waddr_o  out  ADDR_WIDTH  write address.
- rf_wdata_o  out  DATA_WIDTH  write data.
- pc_we_o  out  1  PC restore strobe.
- pc_o  out  DATA_WIDTH  restored PC (checkpoint register).
- busy_o  out  1  recovery in progress.
- recovery_done_o  out  1  single-cycle completion pulse.
- recovery_count_o  out  8  number of completed recoveries, saturating at 255.

Behaviour:
- Reset (async, any state):
  - state IDLE; address counter, write stage, pc checkpoint, start_q, source_sel_q and recovery_count_o all 0.
  - All strobes low.
- Start detection:
  - start_q registers start_i every cycle.
  - A start is the condition start_i=1 and start_q=0 while in IDLE.
  - A start edge arriving while busy is ignored, with no queuing.
  - A level held high after DONE does not retrigger.
- PC checkpoint: pc_q <= pc_i each cycle with load_pc_i=1 and state IDLE. pc_o = pc_q at all times.
- States are IDLE, COPY, DRAIN, PC_RESTORE, DONE.
- IDLE:
  - On start: cnt <= 0, source_sel_q <= source_sel_i, go to COPY.
- COPY:
  - rf_re_o = 1 and rf_raddr_o = cnt.
  - Write stage registers: wr_valid_q <= 1, wr_addr_q <= cnt.
  - If cnt == NUM_REGS-1, go to DRAIN; otherwise cnt <= cnt+1.
- Write stage (all states):
  - rf_we_o = wr_valid_q; rf_waddr_o = wr_addr_q.
  - rf_wdata_o = source_sel_q ? rf_rdata_b_i : rf_rdata_a_i (combinational).
  - wr_valid_q clears in any state other than COPY.
- DRAIN: final write (address NUM_REGS-1) retires; go to PC_RESTORE.
- PC_RESTORE: pc_we_o = 1 for one cycle; go to DONE.
- DONE:
  - recovery_done_o = 1 for one cycle; recovery_count_o increments, saturating at 255; go to IDLE.
- busy_o = 1 in every state except IDLE.
- Latency: with start seen at posedge 0, the sequence is
  - reads in cycles 1..NUM_REGS;
  - writes in cycles 2..NUM_REGS+1;
  - pc_we_o in cycle NUM_REGS+2;
  - recovery_done_o in cycle NUM_REGS+3.
  - For NUM_REGS=32: done in cycle 35; busy_o high for 35 cycles.
- rf_raddr_o and rf_waddr_o are 0 when their strobes are low.
- source_sel_i and pc_i changes during busy have no effect.
- Reset mid-recovery: immediate IDLE. No further writes, no done pulse, count unchanged; the pc checkpoint is lost (0).

Test Plan:
- Basic copy:
  - Stimulus: source_sel_i=0, core A reg k = 0xA000_0000+k; one start pulse.
  - Required: 32 writes, address k with data 0xA000_0000+k, in cycles 2..33. pc_we_o in cycle 34, recovery_done_o in cycle 35 (one cycle), count = 1.
- Source select:
  - Stimulus: source_sel_i=1 at start, then toggled to 0 mid-copy.
  - Required: all 32 writes carry core B data.
- PC checkpoint:
  - Stimulus: load_pc_i=1 with pc_i=0x100, 0x104, 0x108; load_pc_i drops; pc_i=0xDEAD; start.
  - Required: pc_o=0x108 at pc_we_o.
- Retrigger:
  - Stimulus: start_i held high 4 cycles, a second rising edge at cycle 10, and high after done.
  - Required: exactly one recovery, count = 1.
- Reset mid-op:
  - Stimulus: assert rst_i at cycle 12.
  - Required: rf_we_o/busy_o drop asynchronously, no done pulse, a new start runs a full 35-cycle sequence.
- Saturation:
  - Stimulus: 256 recoveries.
  - Required: recovery_count_o = 255.
